// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants, framebuffer geometry and pixel helpers
// for the framebuffer scan-out path.
package vga_pkg;

    localparam int unsigned VGA_CLK_DIV  = 2;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_FB_W     = 320;
    localparam int unsigned VGA_FB_H     = 240;
    localparam int unsigned VGA_ADDR_W   = 17;
    localparam int unsigned VGA_RD_LAT   = 1;

    typedef logic [2:0]            pixel_t;
    typedef logic [VGA_ADDR_W-1:0] fb_addr_t;

    // {R,G,B} bits each widen to a full-scale 4-bit channel
    function automatic logic [11:0] pixel_to_rgb12(input pixel_t p);
        return {{4{p[2]}}, {4{p[1]}}, {4{p[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider and h/v raster counters producing raw (undelayed)
// sync, active-area and frame-start indications.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          i_clk,
    input  logic          reset,
    output logic          o_tick,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output logic          o_hs_n,
    output logic          o_vs_n,
    output logic          o_active,
    output logic          o_frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_frame_start;
    logic          w_tick;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_div         <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && (r_h == '0) && (r_v == '0);
            if (w_tick) begin
                r_div <= '0;
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
                end else begin
                    r_h <= r_h + HW'(1);
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    assign o_tick        = w_tick;
    assign o_h           = r_h;
    assign o_v           = r_v;
    assign o_hs_n        = !((r_h >= HS_BEG) && (r_h < HS_END));
    assign o_vs_n        = !((r_v >= VS_BEG) && (r_v < VS_END));
    assign o_active      = (r_h < H_ACT) && (r_v < V_ACT);
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out: 2x2-doubled read addressing, double-buffer swap at
// vertical blank, and a two-tick read pipeline feeding sync-aligned VGA colour.
module fb_scanout_reader
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned FB_W     = VGA_FB_W,
    parameter int unsigned FB_H     = VGA_FB_H,
    parameter int unsigned ADDR_W   = VGA_ADDR_W,
    parameter int unsigned RD_LAT   = VGA_RD_LAT
) (
    input  logic              i_clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_en,
    input  logic [2:0]        i_rd_data,
    output logic              o_buf_sel,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic              o_frame_start,
    output logic              o_vga_hs,
    output logic              o_vga_vs,
    output logic [3:0]        o_vga_r,
    output logic [3:0]        o_vga_g,
    output logic [3:0]        o_vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

    if (RD_LAT >= CLK_DIV) begin : g_bad_rd_lat
        $error("fb_scanout_reader: RD_LAT must be smaller than CLK_DIV");
    end
    if ((2 * FB_W != H_ACTIVE) || (2 * FB_H != V_ACTIVE)) begin : g_bad_fb_dims
        $error("fb_scanout_reader: framebuffer must be half the active raster");
    end

    logic          w_tick;
    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_active;
    logic          w_frame_start;
    logic          w_swap_now;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .reset         (reset),
        .o_tick        (w_tick),
        .o_h           (w_h),
        .o_v           (w_v),
        .o_hs_n        (w_hs_n),
        .o_vs_n        (w_vs_n),
        .o_active      (w_active),
        .o_frame_start (w_frame_start)
    );

    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic              r_buf_sel;
    logic              r_swap_ack;
    logic              r_hs_a, r_vs_a, r_act_a;
    logic              r_hs_b, r_vs_b, r_act_b;
    pixel_t            r_pix;
    logic [11:0]       r_rgb;
    logic              r_hs_o, r_vs_o;

    // First tick of the first blanking line: the only point a swap may land
    assign w_swap_now = w_tick && (w_h == '0) && (w_v == V_ACT) && i_swap_req;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_row_base <= '0;
            r_rd_addr  <= '0;
            r_rd_en    <= 1'b0;
            r_buf_sel  <= 1'b0;
            r_swap_ack <= 1'b0;
            r_hs_a     <= 1'b1;
            r_vs_a     <= 1'b1;
            r_act_a    <= 1'b0;
            r_hs_b     <= 1'b1;
            r_vs_b     <= 1'b1;
            r_act_b    <= 1'b0;
            r_pix      <= '0;
            r_rgb      <= '0;
            r_hs_o     <= 1'b1;
            r_vs_o     <= 1'b1;
        end else begin
            r_rd_en    <= w_tick && w_active;
            r_swap_ack <= w_swap_now;
            if (w_swap_now) begin
                r_buf_sel <= ~r_buf_sel;
            end
            if (w_tick) begin
                // Each framebuffer row covers two raster lines, so advance after odd lines
                if (w_h == H_LAST) begin
                    if (w_v == V_LAST) begin
                        r_row_base <= '0;
                    end else if (w_v[0] && (w_v < V_ACT)) begin
                        r_row_base <= r_row_base + ADDR_W'(FB_W);
                    end
                end
                if (w_active) begin
                    r_rd_addr <= r_row_base + ADDR_W'(w_h >> 1);
                end
                r_hs_a  <= w_hs_n;
                r_vs_a  <= w_vs_n;
                r_act_a <= w_active;
                r_pix   <= i_rd_data;
                r_hs_b  <= r_hs_a;
                r_vs_b  <= r_vs_a;
                r_act_b <= r_act_a;
                r_rgb   <= r_act_b ? pixel_to_rgb12(r_pix) : '0;
                r_hs_o  <= r_hs_b;
                r_vs_o  <= r_vs_b;
            end
        end
    end

    assign o_rd_addr     = r_rd_addr;
    assign o_rd_en       = r_rd_en;
    assign o_buf_sel     = r_buf_sel;
    assign o_swap_ack    = r_swap_ack;
    assign o_frame_start = w_frame_start;
    assign o_vga_hs      = r_hs_o;
    assign o_vga_vs      = r_vs_o;
    assign o_vga_r       = r_rgb[11:8];
    assign o_vga_g       = r_rgb[7:4];
    assign o_vga_b       = r_rgb[3:0];

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader on a scaled-down raster (24x12 ticks,
// 8x4 framebuffer) so whole frames fit in a short run.
module tb_fb_scanout_reader;

    localparam int unsigned CD  = 2;
    localparam int unsigned HA  = 16;
    localparam int unsigned HF  = 2;
    localparam int unsigned HS  = 4;
    localparam int unsigned HB  = 2;
    localparam int unsigned VA  = 8;
    localparam int unsigned VF  = 1;
    localparam int unsigned VS  = 2;
    localparam int unsigned VB  = 1;
    localparam int unsigned FBW = 8;
    localparam int unsigned FBH = 4;
    localparam int unsigned AW  = 17;

    localparam int unsigned HT        = HA + HF + HS + HB;   // 24 ticks per line
    localparam int unsigned VT        = VA + VF + VS + VB;   // 12 lines per frame
    localparam int unsigned LINE_CLK  = HT * CD;             // 48
    localparam int unsigned FRAME_CLK = VT * LINE_CLK;       // 576
    localparam int unsigned SWAP_OFS  = VA * LINE_CLK;       // 384

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [2:0]    rd_data;
    logic          buf_sel;
    logic          swap_req;
    logic          swap_ack;
    logic          frame_start;
    logic          hs, vs;
    logic [3:0]    vr, vg, vb;

    always #5 clk = ~clk;

    fb_scanout_reader #(
        .CLK_DIV  (CD),
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB),
        .FB_W     (FBW),
        .FB_H     (FBH),
        .ADDR_W   (AW),
        .RD_LAT   (1)
    ) dut (
        .i_clk         (clk),
        .reset         (reset),
        .o_rd_addr     (rd_addr),
        .o_rd_en       (rd_en),
        .i_rd_data     (rd_data),
        .o_buf_sel     (buf_sel),
        .i_swap_req    (swap_req),
        .o_swap_ack    (swap_ack),
        .o_frame_start (frame_start),
        .o_vga_hs      (hs),
        .o_vga_vs      (vs),
        .o_vga_r       (vr),
        .o_vga_g       (vg),
        .o_vga_b       (vb)
    );

    int mem_mode = 0;

    function automatic logic [2:0] mem_val(input logic [AW-1:0] a);
        if (mem_mode == 0) return a[2:0];
        return (a == AW'(5)) ? 3'b101 : 3'b000;
    endfunction

    // One-cycle read latency; junk outside the valid cycle exposes misaligned capture
    always @(posedge clk) rd_data <= rd_en ? mem_val(rd_addr) : 3'b010;

    function automatic logic [11:0] rgb_of(input logic [2:0] p);
        logic [11:0] c;
        c = 12'h000;
        if (p[2]) c[11:8] = 4'hF;
        if (p[1]) c[7:4]  = 4'hF;
        if (p[0]) c[3:0]  = 4'hF;
        return c;
    endfunction

    function automatic int exp_addr(input int k);
        return ((k / HA) / 2) * FBW + (k % HA) / 2;
    endfunction

    function automatic int exp_rd_time(input int k);
        return CD * ((k / HA) * HT + (k % HA));
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    int          cyc = 0;
    int          t_fs = 0, t_hs = 0, t_vs = 0;
    int          rd_k = 0, ack_cnt = 0, f0f_cnt = 0;
    bit          fs_seen, frame_valid, hs_fell, vs_fell;
    logic        prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0, prev_rd_en = 1'b0, prev_bs = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [11:0] exp_rgb [8];

    // Advance to the next falling edge and audit everything visible there
    task automatic step();
        bit          rst_edge;
        logic [11:0] rgb;
        rst_edge = reset;
        @(negedge clk);
        cyc++;
        rgb = {vr, vg, vb};
        if (rst_edge) begin
            fs_seen = 0; frame_valid = 0; hs_fell = 0; vs_fell = 0; rd_k = 0;
            foreach (exp_rgb[i]) exp_rgb[i] = '0;
        end else begin
            check("rgb", 32'(rgb), 32'(exp_rgb[cyc % 8]));
            exp_rgb[cyc % 8] = '0;
            if (rgb == 12'hF0F) f0f_cnt++;
            if (frame_start) begin
                check("fs_width", 32'(prev_fs), 0);
                if (fs_seen) check("fs_period", 32'(cyc - t_fs), FRAME_CLK);
                if (frame_valid) begin
                    check("rd_count", 32'(rd_k), HA * VA);
                    check("last_addr", 32'(last_addr), 32'(exp_addr(HA * VA - 1)));
                end
                fs_seen = 1; frame_valid = 1; t_fs = cyc; rd_k = 0;
            end
            if (rd_en) begin
                check("rd_en_width", 32'(prev_rd_en), 0);
                if (frame_valid) begin
                    check("rd_time", 32'(cyc - t_fs), 32'(exp_rd_time(rd_k)));
                    check("rd_addr", 32'(rd_addr), 32'(exp_addr(rd_k)));
                end
                rd_k++;
                last_addr = rd_addr;
                exp_rgb[(cyc + 4) % 8] = rgb_of(mem_val(rd_addr));
                exp_rgb[(cyc + 5) % 8] = rgb_of(mem_val(rd_addr));
            end
            if (!hs && prev_hs) begin
                if (hs_fell) check("hs_period", 32'(cyc - t_hs), LINE_CLK);
                hs_fell = 1; t_hs = cyc;
            end
            if (hs && !prev_hs && hs_fell) check("hs_low", 32'(cyc - t_hs), HS * CD);
            if (!vs && prev_vs) begin
                if (vs_fell) check("vs_period", 32'(cyc - t_vs), FRAME_CLK);
                vs_fell = 1; t_vs = cyc;
            end
            if (vs && !prev_vs && vs_fell) check("vs_low", 32'(cyc - t_vs), VS * LINE_CLK);
            if (swap_ack) begin
                ack_cnt++;
                check("ack_pos", 32'(cyc - t_fs), SWAP_OFS);
            end
            if (buf_sel != prev_bs) begin
                check("bs_pos", 32'(cyc - t_fs), SWAP_OFS);
                check("bs_with_ack", 32'(swap_ack), 1);
            end
        end
        prev_hs = hs; prev_vs = vs; prev_fs = frame_start;
        prev_rd_en = rd_en; prev_bs = buf_sel;
    endtask

    task automatic wait_fs();
        bit found;
        found = 0;
        for (int i = 0; i < int'(FRAME_CLK) + 16; i++) begin
            step();
            if (frame_start) begin
                found = 1;
                break;
            end
        end
        check("fs_wait", 32'(found), 1);
    endtask

    task automatic run_to(input int ofs);
        while (cyc - t_fs < ofs) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(rd_addr), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_buf_sel"}, 32'(buf_sel), 0);
        check({tag, "_ack"}, 32'(swap_ack), 0);
        check({tag, "_fs"}, 32'(frame_start), 0);
        check({tag, "_hs"}, 32'(hs), 1);
        check({tag, "_vs"}, 32'(vs), 1);
        check({tag, "_rgb"}, 32'({vr, vg, vb}), 0);
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        swap_req = 1'b0;
        foreach (exp_rgb[i]) exp_rgb[i] = '0;

        repeat (3) step();
        check_reset_outputs("rst");
        reset = 1'b0;

        // Two full frames of sync, address-sweep and colour checks
        wait_fs();
        wait_fs();
        wait_fs();

        // Single lit pixel at address 5
        mem_mode = 1;
        f0f_cnt  = 0;
        wait_fs();
        check("f0f_count", 32'(f0f_cnt), 4 * CD);

        // Request that ends well before vertical blank must be ignored
        ack_cnt = 0;
        run_to(4 * LINE_CLK);
        swap_req = 1'b1;
        repeat (LINE_CLK) step();
        swap_req = 1'b0;
        wait_fs();
        check("pulse_acks", 32'(ack_cnt), 0);
        check("pulse_bs", 32'(buf_sel), 0);

        // Held request: one toggle per frame
        run_to(6 * LINE_CLK);
        swap_req = 1'b1;
        wait_fs();
        check("hold1_acks", 32'(ack_cnt), 1);
        check("hold1_bs", 32'(buf_sel), 1);
        wait_fs();
        check("hold2_acks", 32'(ack_cnt), 2);
        check("hold2_bs", 32'(buf_sel), 0);
        wait_fs();
        check("hold3_acks", 32'(ack_cnt), 3);
        check("hold3_bs", 32'(buf_sel), 1);
        swap_req = 1'b0;

        // Reset in the middle of active line v=4, h=10
        run_to(CD * (4 * HT + 10));
        check("pre_rst_bs", 32'(buf_sel), 1);
        reset = 1'b1;
        step();
        check_reset_outputs("mid_rst");
        step();
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rd_en) begin
                found = 1;
                break;
            end
        end
        check("post_rst_rd_seen", 32'(found), 1);
        check("post_rst_addr", 32'(rd_addr), 0);
        check("post_rst_bs", 32'(buf_sel), 0);
        check("post_rst_fs", 32'(frame_start), 1);
        wait_fs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
- Read side of the 320x240, 3-bit-per-pixel framebuffer that the command front-end writes by row*320+col address.
- Generates 640x480@60 VGA timing from i_clk and issues framebuffer read addresses with 2x2 pixel doubling.
- Turns the returned 3-bit pixels into 4-bit-per-channel VGA colour.
- Supports double-buffer selection, swapped only at start of vertical blank on request.

Parameters:
- CLK_DIV, 2: i_clk cycles per pixel tick (50 MHz -> 25 MHz).
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixel ticks.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- FB_W, 320 / FB_H, 240: framebuffer dimensions.
- ADDR_W, 17: read address width.
- RD_LAT, 1: memory read latency in i_clk cycles. Must be < CLK_DIV; elaboration error otherwise.

Ports:
- i_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- o_rd_addr  out  ADDR_W  framebuffer read address, (v>>1)*FB_W + (h>>1)
- o_rd_en  out  1  read strobe; high for one i_clk on each active-area pixel tick
- i_rd_data  in  3  pixel {R,G,B}; valid RD_LAT cycles after o_rd_en
- o_buf_sel  out  1  buffer being scanned; memory uses it as address MSB
- i_swap_req  in  1  level request to toggle o_buf_sel at next vertical blank
- o_swap_ack  out  1  one-cycle pulse when the swap is applied
- o_frame_start  out  1  one-cycle pulse on the tick where h=0, v=0
- o_vga_hs, o_vga_vs  out  1  sync outputs, active low
- o_vga_r, o_vga_g, o_vga_b  out  4  colour outputs

Behaviour:
- Reset values:
  - h=0, v=0, tick divider=0, row base=0.
  - o_rd_addr=0, o_rd_en=0, o_buf_sel=0, o_swap_ack=0, o_frame_start=0.
  - hs=1, vs=1, RGB=0.
  - Reset mid-frame restarts timing at h=0, v=0 on the next tick. Pipeline contents are discarded and outputs forced to reset values.
- Pixel tick: divider counts 0..CLK_DIV-1; tick is asserted when divider==CLK_DIV-1.
- Counters:
  - h counts 0..799 on each tick and wraps to 0.
  - v increments when h wraps, counting 0..524 and wrapping to 0.
- Read address:
  - No multiplier. Row base register adds FB_W when h wraps and v is odd (v<480); it clears when v wraps.
  - Address = row base + (h>>1).
  - At h=0, v=0 the address is 0. At h=639, v=479 it is 239*320+319 = 76799 (max).
- Pipeline, 2 ticks deep:
  - Tick N: address and o_rd_en issued for (h,v), active area only.
  - Tick N+1: i_rd_data registered. It is guaranteed valid because RD_LAT < CLK_DIV.
  - Tick N+2: colour and delayed syncs drive the outputs.
  - hs, vs and active flag are delayed by the same 2 ticks so colour stays aligned with sync.
- Sync timing (undelayed):
  - hs low for 656<=h<752.
  - vs low for 490<=v<492.
- Colour: pixel bit2->R, bit1->G, bit0->B. Each bit expands to 4'hF or 4'h0. RGB=0 whenever the delayed active flag is 0.
- Swap:
  - On the tick where h=0 and v=480 (first blank line), if i_swap_req=1 then o_buf_sel toggles and o_swap_ack pulses for exactly one i_clk.
  - A request dropped before that tick is ignored.
  - A request held high swaps once per frame.
  - o_buf_sel never changes during the active area.
- o_frame_start pulses on the tick where undelayed h=0 and v=0.
- o_rd_en is never high outside active area (h>=640 or v>=480).

Decomposition:
- Package vga_pkg:
  - 640x480 timing constants and framebuffer dimensions.
  - typedef pixel_t (logic[2:0]) and typedef fb_addr_t (logic[ADDR_W-1:0]).
  - Helper function expanding pixel_t to 12-bit RGB.
- One sub-module vga_timing_gen: tick divider, h/v counters, raw hs/vs/active, frame_start.
- fb_scanout_reader owns address generation, the read pipeline, swap logic and colour output.

Test Plan:
- Sync check, reset for 3 cycles then run 2 frames.
  - hs period is 1600 i_clk with a 192-cycle low pulse.
  - vs period is 840000 i_clk with a 3200-cycle low pulse.
  - o_frame_start pulses exactly every 840000 i_clk.
- Address sweep with a memory model returning addr[2:0].
  - First active line issues addresses 0,0,1,1,...,319,319; line v=1 repeats them; v=2 starts at 320.
  - The last read of the frame is 76799.
  - Exactly 307200 o_rd_en pulses per frame.
- Colour alignment: memory returns 3'b101 at address 5 only.
  - RGB = F,0,F appears 2 ticks after the address-5 read, for exactly 2 ticks.
  - All other active pixels are 0; blanking RGB is 0.
- Swap, with i_swap_req pulsed during v=100.
  - No swap occurs (the request ended before v=480).
  - Holding i_swap_req from v=300 through v=480: o_buf_sel goes 0->1 at h=0, v=480 with a single o_swap_ack.
  - Keeping the request held toggles back to 0 on the next frame.
- Reset mid-operation, at h=400, v=200.
  - Outputs go to reset values next cycle.
  - After release the first o_rd_en carries address 0 and the buffer select is 0.
